// File: rtl/fft_stage_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package : fft_stage_sequencer_pkg
// Brief   : FSM state encoding and default FFT geometry, shared with the index mappers.
// Rev     : 1.0  initial release
// ============================================================================
package fft_stage_sequencer_pkg;

  localparam int N_DEF      = 32;
  localparam int MSB_DEF    = 5;
  localparam int BF_LAT_DEF = 3;
  localparam int STAGES     = $clog2(N_DEF);
  localparam int IDX_W      = MSB_DEF;
  localparam int STAGE_W    = $clog2(MSB_DEF);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/fft_stage_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : fft_stage_sequencer_if
// Brief     : Control/read/write-back bundle of the FFT stage sequencer
//             (hold_i present only when FFT_SEQ_HOLD_EN is defined).
// Rev       : 1.0  initial release
// ============================================================================
interface fft_stage_sequencer_if #(
  parameter int MSB = fft_stage_sequencer_pkg::MSB_DEF
);
  localparam int STG_W = $clog2(MSB);

  logic             start_i;
`ifdef FFT_SEQ_HOLD_EN
  logic             hold_i;
`endif
  logic             rd_en_o;
  logic [MSB-1:0]   rd_idx_a_o;
  logic [MSB-1:0]   rd_idx_b_o;
  logic [STG_W-1:0] rd_stage_o;
  logic             wr_en_o;
  logic [MSB-1:0]   wr_idx_a_o;
  logic [MSB-1:0]   wr_idx_b_o;
  logic [STG_W-1:0] wr_stage_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    input  start_i,
`ifdef FFT_SEQ_HOLD_EN
    input  hold_i,
`endif
    output rd_en_o, rd_idx_a_o, rd_idx_b_o, rd_stage_o,
    output wr_en_o, wr_idx_a_o, wr_idx_b_o, wr_stage_o,
    output busy_o, done_o
  );

  modport slave (
    output start_i,
`ifdef FFT_SEQ_HOLD_EN
    output hold_i,
`endif
    input  rd_en_o, rd_idx_a_o, rd_idx_b_o, rd_stage_o,
    input  wr_en_o, wr_idx_a_o, wr_idx_b_o, wr_stage_o,
    input  busy_o, done_o
  );

endinterface
`default_nettype wire

// File: rtl/fft_stage_sequencer_delay.sv
`default_nettype none
// ============================================================================
// Module : fft_seq_delay
// Brief  : DEPTH-stage shift register with synchronous clear and shift enable.
// Rev    : 1.0  initial release
// ============================================================================
module fft_seq_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else if (en_i) begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module : fft_stage_sequencer
// Brief  : Walks butterfly pair indices over all log2(N) radix-2 stages and
//          delays them by BF_LAT to form write-back indices.
//          Optional stall input enabled by defining FFT_SEQ_HOLD_EN.
// Rev    : 1.0  initial release
// ============================================================================
module fft_stage_sequencer
  import fft_stage_sequencer_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int MSB    = MSB_DEF,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_stage_sequencer_if.master bus
);

  localparam int STG_W = $clog2(MSB);
  localparam int CNT_W = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam int DLY_W = 1 + 2*MSB + STG_W;
  localparam logic [MSB-2:0]   K_LAST   = (MSB-1)'(N/2 - 1);
  localparam logic [MSB-2:0]   K_ONE    = (MSB-1)'(1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(MSB - 1);
  localparam logic [STG_W-1:0] STG_ONE  = STG_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BF_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  seq_state_e       state_q;
  logic [MSB-2:0]   k_q;
  logic [STG_W-1:0] stage_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rd_en_q;
  logic             busy_q;
  logic             done_q;
  logic             hold_act;
  logic             rd_en_w;
  logic [MSB-1:0]   rd_idx_a_w;
  logic [MSB-1:0]   rd_idx_b_w;
  logic [DLY_W-1:0] dly_w;

`ifdef FFT_SEQ_HOLD_EN
  assign hold_act = bus.hold_i && (state_q == S_ISSUE || state_q == S_DRAIN);
`else
  assign hold_act = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!hold_act) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            state_q <= S_ISSUE;
            k_q     <= '0;
            stage_q <= '0;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (k_q == K_LAST) begin
            state_q <= S_DRAIN;
            k_q     <= '0;
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
          end else begin
            k_q <= k_q + K_ONE;
          end
        end
        S_DRAIN: begin
          // Next stage may only read once every write of this stage has landed.
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (stage_q == STG_LAST) begin
              state_q <= S_DONE;
              stage_q <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
              stage_q <= stage_q + STG_ONE;
              rd_en_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Odd index takes its LSB from rd_en_q so every index reads zero when idle.
  assign rd_en_w    = rd_en_q & ~hold_act;
  assign rd_idx_a_w = {k_q, 1'b0};
  assign rd_idx_b_w = {k_q, rd_en_q};

  assign bus.rd_en_o    = rd_en_w;
  assign bus.rd_idx_a_o = rd_idx_a_w;
  assign bus.rd_idx_b_o = rd_idx_b_w;
  assign bus.rd_stage_o = stage_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;

  fft_seq_delay #(
    .W     (DLY_W),
    .DEPTH (BF_LAT)
  ) u_delay (
    .clk   (clk),
    .clr_i (reset),
    .en_i  (~hold_act),
    .d_i   ({rd_en_w, rd_idx_a_w, rd_idx_b_w, stage_q}),
    .q_o   (dly_w)
  );

  assign bus.wr_en_o    = dly_w[DLY_W-1] & ~hold_act;
  assign bus.wr_idx_a_o = dly_w[DLY_W-2 -: MSB];
  assign bus.wr_idx_b_o = dly_w[DLY_W-2-MSB -: MSB];
  assign bus.wr_stage_o = dly_w[STG_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// Bench for fft_stage_sequencer: a cycle-level reference model queues expected
// read/write/done events; a negedge monitor pops and compares them.
module tb_fft_stage_sequencer;

  localparam int N      = 32;
  localparam int MSB    = 5;
  localparam int BF_LAT = 3;
  localparam int P      = N/2 + BF_LAT;
  localparam int TOTAL  = MSB * P;

  typedef struct {
    int cyc;
    int a;
    int b;
    int s;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.MSB(MSB)) bus ();

  fft_stage_sequencer #(
    .N      (N),
    .MSB    (MSB),
    .BF_LAT (BF_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int  vecs = 0;
  int  errs = 0;
  int  cyc  = 0;
  ev_t rd_q[$];
  ev_t wr_q[$];
  int  done_q[$];
  bit  mdl_valid  = 1'b0;
  bit  mdl_active = 1'b0;
  bit  mdl_held   = 1'b0;
  bit  exp_busy   = 1'b0;
  bit  chk_en     = 1'b0;
  int  mdl_r      = 0;
  int  wr_cnt     = 0;
  int  last_done  = -1;
  bit  done_seen  = 1'b0;

  // Position t (1-based, in un-held cycles since start) is a read if it falls in
  // the first N/2 slots of its stage period.
  function automatic bit is_read(input int t);
    return (t >= 1) && (t <= TOTAL) && (((t - 1) % P) < N/2);
  endfunction

  function automatic ev_t mk_ev(input int c, input int t);
    ev_t e;
    int  k;
    k     = (t - 1) % P;
    e.cyc = c;
    e.a   = 2 * k;
    e.b   = 2 * k + 1;
    e.s   = (t - 1) / P;
    return e;
  endfunction

  task automatic expect_cycle(input bit hd);
    chk_en   = mdl_valid;
    exp_busy = mdl_active && (mdl_r >= 1) && (mdl_r <= TOTAL);
    mdl_held = exp_busy && hd;
    if (mdl_active && !mdl_held) begin
      if (is_read(mdl_r))          rd_q.push_back(mk_ev(cyc, mdl_r));
      if (is_read(mdl_r - BF_LAT)) wr_q.push_back(mk_ev(cyc, mdl_r - BF_LAT));
      if (mdl_r == TOTAL + 1)      done_q.push_back(cyc);
    end
  endtask

  task automatic update_model(input bit st, input bit rs);
    if (rs) begin
      mdl_valid  = 1'b1;
      mdl_active = 1'b0;
      mdl_r      = 0;
    end else if (mdl_valid) begin
      if (!mdl_active) begin
        if (st) begin
          mdl_active = 1'b1;
          mdl_r      = 1;
        end
      end else if (!mdl_held) begin
        if (mdl_r == TOTAL + 1) mdl_active = 1'b0;
        else                    mdl_r++;
      end
    end
  endtask

  task automatic step(input bit st, input bit rs, input bit hd);
    bus.start_i = st;
    reset       = rs;
`ifdef FFT_SEQ_HOLD_EN
    bus.hold_i  = hd;
`endif
    expect_cycle(hd);
    @(posedge clk);
    #1;
    update_model(st, rs);
    cyc++;
  endtask

  task automatic cmp_ev(input string nm, input bit have, input ev_t e,
                        input int a, input int b, input int s);
    vecs++;
    if (!have) begin
      errs++;
      $display("FAIL %s unexpected cyc=%0d got a=%0d b=%0d stage=%0d want no event", nm, cyc, a, b, s);
    end else if (e.cyc != cyc || e.a != a || e.b != b || e.s != s) begin
      errs++;
      $display("FAIL %s cyc=%0d got a=%0d b=%0d stage=%0d want cyc=%0d a=%0d b=%0d stage=%0d",
               nm, cyc, a, b, s, e.cyc, e.a, e.b, e.s);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    vecs++;
    if (got != want) begin
      errs++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic check_zero(input string nm);
    logic [31:0] v;
    v = 32'({bus.rd_en_o, bus.rd_idx_a_o, bus.rd_idx_b_o, bus.rd_stage_o,
             bus.wr_en_o, bus.wr_idx_a_o, bus.wr_idx_b_o, bus.wr_stage_o,
             bus.busy_o, bus.done_o});
    vecs++;
    if (v !== 32'd0) begin
      errs++;
      $display("FAIL %s outputs got=%h want=0", nm, v);
    end
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !done_seen; i++) step(1'b0, 1'b0, 1'b0);
    if (!done_seen) begin
      vecs++;
      errs++;
      $display("FAIL done_timeout got=none want=done within %0d cycles", limit);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    bit  have;
    if (chk_en) begin
      vecs++;
      if (bus.busy_o !== exp_busy) begin
        errs++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, bus.busy_o, exp_busy);
      end
      if (bus.rd_en_o === 1'b1) begin
        have = rd_q.size() > 0;
        if (have) e = rd_q.pop_front();
        cmp_ev("rd", have, e, int'(bus.rd_idx_a_o), int'(bus.rd_idx_b_o), int'(bus.rd_stage_o));
      end else if (bus.rd_en_o !== 1'b0 || (rd_q.size() > 0 && rd_q[0].cyc <= cyc)) begin
        if (rd_q.size() > 0) e = rd_q.pop_front();
        vecs++;
        errs++;
        $display("FAIL rd_missing cyc=%0d got rd_en=%b want rd_en=1", cyc, bus.rd_en_o);
      end
      if (bus.wr_en_o === 1'b1) begin
        wr_cnt++;
        have = wr_q.size() > 0;
        if (have) e = wr_q.pop_front();
        cmp_ev("wr", have, e, int'(bus.wr_idx_a_o), int'(bus.wr_idx_b_o), int'(bus.wr_stage_o));
      end else if (bus.wr_en_o !== 1'b0 || (wr_q.size() > 0 && wr_q[0].cyc <= cyc)) begin
        if (wr_q.size() > 0) e = wr_q.pop_front();
        vecs++;
        errs++;
        $display("FAIL wr_missing cyc=%0d got wr_en=%b want wr_en=1", cyc, bus.wr_en_o);
      end
      if (bus.done_o === 1'b1) begin
        done_seen = 1'b1;
        last_done = cyc;
        check_int("done_cycle", cyc, (done_q.size() > 0) ? done_q.pop_front() : -1);
      end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
        check_int("done_missing", int'(bus.done_o), 1);
        void'(done_q.pop_front());
      end
    end
  end

  initial begin
    int cs;
    bus.start_i = 1'b0;
`ifdef FFT_SEQ_HOLD_EN
    bus.hold_i  = 1'b0;
`endif
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_zero("reset_state");

    // Full run; a second start at +40 must be ignored.
    step(1'b0, 1'b0, 1'b0);
    cs = cyc; done_seen = 1'b0; wr_cnt = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 40; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    wait_done(200);
    check_int("run_latency", last_done - cs, TOTAL + 1);
    check_int("wr_count", wr_cnt, MSB * N / 2);

`ifdef FFT_SEQ_HOLD_EN
    step(1'b0, 1'b0, 1'b0);
    cs = cyc; done_seen = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) step(1'b0, 1'b0, i >= 5);
    wait_done(200);
    check_int("hold_latency", last_done - cs, TOTAL + 1 + 5);
`endif

    // Abort at +50, restart at +60.
    step(1'b0, 1'b0, 1'b0);
    cs = cyc;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 50; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_zero("abort_state");
    wr_cnt = 0; done_seen = 1'b0;
    for (int i = 51; i < 60; i++) step(1'b0, 1'b0, 1'b0);
    check_int("wr_after_abort", wr_cnt, 0);
    check_int("done_after_abort", int'(done_seen), 0);
    step(1'b1, 1'b0, 1'b0);
    wait_done(200);
    check_int("restart_latency", last_done - (cs + 60), TOTAL + 1);

    // Random starts, rare resets and (if present) random holds.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 499) == 0,
`ifdef FFT_SEQ_HOLD_EN
           $urandom_range(0, 3) == 0
`else
           1'b0
`endif
          );
    end
    for (int i = 0; i < 2 * TOTAL; i++) step(1'b0, 1'b0, 1'b0);
    check_int("leftover_events", rd_q.size() + wr_q.size() + done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
